regfile_wb_scheduler: RTL and testbench
=======================================

// Module: regfile_wb_scheduler
// PURPOSE
//   Write-back scheduler for the register file's single write port.
//   - Round-robin arbitration among NUM_REQ write-back requesters (e.g. ALU, LSU).
//   - Registered write stage driving the register file write port.
//   - Per-register busy scoreboard used by issue to detect RAW hazards on read ports A/B.
// PARAMETERS
//   WIDTH    32  data width of a register
//   DEPTH    32  number of registers; AW = $clog2(DEPTH)
//   NUM_REQ  2   write-back requesters; index 0 = ALU, 1 = LSU
// PORTS
//   clk          in   1            clock; all state updates on posedge
//   rst          in   1            reset, asynchronous, active-low
//   req_valid    in   NUM_REQ      requester i holds a write-back
//   req_ready    out  NUM_REQ      requester i granted this cycle
//   req_rd       in   NUM_REQ x AW destination register per requester
//   req_data     in   NUM_REQ x WIDTH write data per requester
//   wr_en        out  1            register file write enable
//   regW         out  AW           register file write address
//   portW        out  WIDTH        register file write data
//   issue_valid  in   1            issue stage launches an instruction with a destination
//   issue_rd     in   AW           destination of the issued instruction
//   regA, regB   in   AW           register file read addresses (shared with register file)
//   busy_a       out  1            busy[regA]
//   busy_b       out  1            busy[regB]
// BEHAVIOUR
//   Arbitration
//   - Round-robin pointer ptr, reset 0. Grant the lowest i >= ptr with req_valid[i] set;
//     wrap to 0 if none. At most one grant per cycle.
//   - req_ready = grant, combinational from req_valid and ptr. Requesters must not make
//     req_valid depend on req_ready. req_valid must hold with stable rd/data until granted.
//   - On a grant to i: ptr <= (i+1) mod NUM_REQ. With no valid request, ptr holds.
//   Write stage (1-cycle latency)
//   - Grant at edge t: wr_en/regW/portW are registered at t and held through cycle t+1.
//     The register file commits the write at edge t+1.
//   - With no grant, wr_en <= 0. regW and portW hold their previous values.
//   - rd == 0: the request is granted (ready=1) and wr_en stays 0. x0 is never written.
//   Scoreboard busy[DEPTH]
//   - issue_valid && issue_rd != 0 -> busy[issue_rd] <= 1.
//   - wr_en && regW != 0 -> busy[regW] <= 0. The clear lands on the same edge the
//     register file is written.
//   - Set and clear of the same register on one edge: set wins.
//   - busy[0] is constant 0. busy_a/busy_b are combinational lookups of busy[regA]/busy[regB].
//   - Issue to an already-busy register (WAW) is a protocol violation. A simulation
//     assertion fires; the bit stays 1.
//   Reset (async, active-low)
//   - wr_en=0, regW=0, portW=0, ptr=0, all busy=0, fwd state=0.
//   - Reset mid-operation drops an in-flight write; no write is committed.
// CONFIGURATION
//   WB_FWD_EN defined adds ports rf_portA/rf_portB (in, WIDTH) and portA/portB (out, WIDTH).
//   - The register file read is synchronous and does not see a same-cycle write.
//   - Per read port, register hit_x <= wr_en && regW==regX && regX!=0, and fwd_x <= portW.
//   - Next cycle: portX = hit_x ? fwd_x : rf_portX.
//   WB_FWD_EN undefined: none of these ports or registers exist.
// STRUCTURE
//   regfile_pkg: WIDTH/DEPTH defaults, addr_t, data_t, and wb_req_t {rd, data}.
//   Sub-module rr_arbiter #(N): inputs req[N], clk, rst; outputs grant[N] (one-hot);
//   contains the pointer state.
// TESTING
//   1. Hold rst=0 for 3 cycles with requests active -> wr_en=0, req_ready=0, busy_a=busy_b=0.
//      Release reset -> first grant goes to requester 0.
//   2. Both requesters valid for 4 cycles, rd=5/6, data=0xA/0xB -> grants alternate 0,1,0,1.
//      wr_en seen one cycle after each grant with matching regW/portW.
//   3. Requester 1 only, rd=0, data=0xFFFFFFFF -> req_ready[1]=1, wr_en stays 0,
//      register 0 still reads 0.
//   4. issue rd=7, then regA=7 -> busy_a=1. Requester 0 writes rd=7 -> busy_a=0 in the cycle
//      after wr_en. Issue rd=7 on the same edge as the write-back clear -> busy stays 1.
//   5. Assert rst mid-burst, with a grant accepted the cycle before -> wr_en=0 immediately,
//      no write to the register file, and all busy bits clear.
//   6. (WB_FWD_EN) Write rd=3 data=0x1234 while regA=3 -> portA=0x1234 next cycle while
//      rf_portA still returns the old value.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared types for the register-file write-back path.
//   DEF_WIDTH / DEF_DEPTH : default register width and register count
//   addr_t / data_t       : register address and data types at the defaults
//   wb_req_t              : one write-back request {rd, data}
// -----------------------------------------------------------------------------
package regfile_pkg;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 32;
   localparam int DEF_AW    = $clog2(DEF_DEPTH);

   typedef logic [DEF_AW-1:0]    addr_t;
   typedef logic [DEF_WIDTH-1:0] data_t;

   typedef struct packed {
      addr_t rd;
      data_t data;
   } wb_req_t;
endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter with a one-hot grant. Grants the lowest requester at
//   or above the pointer, otherwise wraps to the lowest requester overall.
//   The pointer moves to one past the winner and holds when nobody requests.
//   Ports:
//     clk    in  clock
//     rst    in  asynchronous reset, active-low (grant forced to 0 while low)
//     req    in  N request lines
//     grant  out N one-hot grant, combinational from req and the pointer
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic          hit;

   always_comb begin
      hit   = 1'b0;
      win   = '0;
      grant = '0;
      // first pass: requesters at or above the pointer
      for (int i = 0; i < N; i++) begin
         if (!hit && req[i] && (PW'(i) >= ptr)) begin
            hit = 1'b1;
            win = PW'(i);
         end
      end
      // second pass: wrap around to the lowest requester
      for (int i = 0; i < N; i++) begin
         if (!hit && req[i]) begin
            hit = 1'b1;
            win = PW'(i);
         end
      end
      if (rst && hit) grant[win] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     ptr <= '0;
      else if (hit) ptr <= (win == PW'(N-1)) ? '0 : win + 1'b1;
   end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_wb_scheduler
//   Write-back scheduler for the register file's single write port:
//   round-robin arbitration among NUM_REQ requesters, a registered write
//   stage, and a per-register busy scoreboard for RAW detection at issue.
//   Optional macro WB_FWD_EN adds write-to-read forwarding on ports A/B.
//   Ports:
//     clk, rst            clock; asynchronous active-low reset
//     req_valid/ready     per-requester handshake (ready = grant, combinational)
//     req_rd/req_data     per-requester destination and data
//     wr_en/regW/portW    register file write port (registered)
//     issue_valid/rd      issued instruction with a destination -> mark busy
//     regA/regB           read addresses; busy_a/busy_b = busy[regA]/busy[regB]
//     rf_portA/B (fwd)    synchronous register file read data
//     portA/B    (fwd)    read data with the last write forwarded
// -----------------------------------------------------------------------------
module regfile_wb_scheduler
   import regfile_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int NUM_REQ = 2,
   parameter int AW      = $clog2(DEPTH)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ-1:0][AW-1:0]     req_rd,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]  req_data,
   output logic                           wr_en,
   output logic [AW-1:0]                  regW,
   output logic [WIDTH-1:0]               portW,
   input  logic                           issue_valid,
   input  logic [AW-1:0]                  issue_rd,
   input  logic [AW-1:0]                  regA,
   input  logic [AW-1:0]                  regB,
   output logic                           busy_a,
   output logic                           busy_b
`ifdef WB_FWD_EN
  ,input  logic [WIDTH-1:0]               rf_portA,
   input  logic [WIDTH-1:0]               rf_portB,
   output logic [WIDTH-1:0]               portA,
   output logic [WIDTH-1:0]               portB
`endif
);
   logic [NUM_REQ-1:0] grant;
   logic               sel_vld;
   logic [AW-1:0]      sel_rd;
   logic [WIDTH-1:0]   sel_data;
   logic [DEPTH-1:0]   busy;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (req_valid),
      .grant (grant)
   );

   assign req_ready = grant;

   // grant is one-hot, so at most one requester is selected
   always_comb begin
      sel_vld  = 1'b0;
      sel_rd   = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_vld  = 1'b1;
            sel_rd   = req_rd[i];
            sel_data = req_data[i];
         end
      end
   end

   // write stage: a grant to x0 is consumed but never writes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en <= 1'b0;
         regW  <= '0;
         portW <= '0;
      end else if (sel_vld) begin
         wr_en <= (sel_rd != '0);
         regW  <= sel_rd;
         portW <= sel_data;
      end else begin
         wr_en <= 1'b0;
      end
   end

   // scoreboard: the set is assigned last so it wins over a same-edge clear;
   // x0 is never set, so busy[0] stays 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
      end else begin
         if (wr_en && regW != '0)          busy[regW]     <= 1'b0;
         if (issue_valid && issue_rd != '0) busy[issue_rd] <= 1'b1;
      end
   end

   assign busy_a = busy[regA];
   assign busy_b = busy[regB];

`ifndef SYNTHESIS
   // issuing to a register that is still pending (and not retiring this edge) is a WAW
   always @(posedge clk) begin
      if (rst && issue_valid && issue_rd != '0 && !(wr_en && regW == issue_rd))
         assert (!busy[issue_rd])
            else $error("WAW issue to busy register %0d", issue_rd);
   end
`endif

`ifdef WB_FWD_EN
   // the register file read does not see the write committed on the same edge,
   // so remember that write and substitute it for one cycle
   logic             hit_a, hit_b;
   logic [WIDTH-1:0] fwd_a, fwd_b;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_a <= 1'b0;
         hit_b <= 1'b0;
         fwd_a <= '0;
         fwd_b <= '0;
      end else begin
         hit_a <= wr_en && (regW == regA) && (regA != '0);
         hit_b <= wr_en && (regW == regB) && (regB != '0);
         fwd_a <= portW;
         fwd_b <= portW;
      end
   end

   assign portA = hit_a ? fwd_a : rf_portA;
   assign portB = hit_b ? fwd_b : rf_portB;
`endif
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;
   localparam int NR = 2;
   localparam int W  = 32;
   localparam int D  = 32;
   localparam int A  = 5;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NR-1:0]          req_valid;
   logic [NR-1:0]          req_ready;
   logic [NR-1:0][A-1:0]   req_rd;
   logic [NR-1:0][W-1:0]   req_data;
   logic                   wr_en;
   logic [A-1:0]           regW;
   logic [W-1:0]           portW;
   logic                   issue_valid;
   logic [A-1:0]           issue_rd;
   logic [A-1:0]           regA, regB;
   logic                   busy_a, busy_b;
`ifdef WB_FWD_EN
   logic [W-1:0]           rf_portA, rf_portB, portA, portB;
`endif

   int checks = 0;
   int errors = 0;

   regfile_wb_scheduler #(.WIDTH(W), .DEPTH(D), .NUM_REQ(NR)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_rd(req_rd), .req_data(req_data),
      .wr_en(wr_en), .regW(regW), .portW(portW),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .regA(regA), .regB(regB), .busy_a(busy_a), .busy_b(busy_b)
`ifdef WB_FWD_EN
     ,.rf_portA(rf_portA), .rf_portB(rf_portB), .portA(portA), .portB(portB)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // environment register file: commits on the write edge, synchronous read
   logic [W-1:0] rf_mem [D] = '{default: '0};
   int           commits = 0;
   always @(posedge clk) begin
      if (wr_en && regW != '0) begin
         rf_mem[regW] <= portW;
         commits      <= commits + 1;
      end
`ifdef WB_FWD_EN
      rf_portA <= rf_mem[regA];
      rf_portB <= rf_mem[regB];
`endif
   end

   // ---------------- behavioural model + per-cycle compare ----------------
   int           m_ptr = 0;
   bit           m_busy [D];
   logic [W-1:0] m_arch [D] = '{default: '0};
   bit           m_wr = 0;
   logic [A-1:0] m_regW = '0;
   logic [W-1:0] m_portW = '0;
   logic [A-1:0] m_rdA = '0, m_rdB = '0;
   bit           fwd_ok = 0;

   always @(negedge clk) begin : cmp
      int            g;
      logic [NR-1:0] exp_ready;
      if (!rst) begin
         m_ptr = 0; m_wr = 0; m_regW = '0; m_portW = '0; fwd_ok = 0;
         foreach (m_busy[i]) m_busy[i] = 0;
         chk("cmp_rst_ready", req_ready, 0);
         chk("cmp_rst_wr_en", wr_en, 0);
         chk("cmp_rst_regW", regW, 0);
         chk("cmp_rst_portW", portW, 0);
         chk("cmp_rst_busy_a", busy_a, 0);
         chk("cmp_rst_busy_b", busy_b, 0);
      end else begin
         // rotate through requesters starting at the pointer
         g = -1;
         for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_ptr + k) % NR;
            if (g < 0 && req_valid[i]) g = i;
         end
         exp_ready = (g >= 0) ? NR'(1) << g : '0;
         chk("cmp_ready", req_ready, exp_ready);
         chk("cmp_wr_en", wr_en, m_wr);
         if (m_wr) begin
            chk("cmp_regW", regW, m_regW);
            chk("cmp_portW", portW, m_portW);
         end
         chk("cmp_busy_a", busy_a, m_busy[regA]);
         chk("cmp_busy_b", busy_b, m_busy[regB]);
`ifdef WB_FWD_EN
         if (fwd_ok) begin
            chk("cmp_portA", portA, m_arch[m_rdA]);
            chk("cmp_portB", portB, m_arch[m_rdB]);
         end
`endif
         // state after the coming edge
         if (m_wr && m_regW != 0) begin
            m_arch[m_regW] = m_portW;
            m_busy[m_regW] = 0;
         end
         if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
         if (g >= 0) begin
            m_wr    = (req_rd[g] != 0);
            m_regW  = req_rd[g];
            m_portW = req_data[g];
            m_ptr   = (g + 1) % NR;
         end else begin
            m_wr = 0;
         end
         m_rdA  = regA;
         m_rdB  = regB;
         fwd_ok = 1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b0;
      req_valid = 2'b11;
      req_rd[0] = 5'd5;  req_rd[1] = 5'd6;
      req_data[0] = 32'hA; req_data[1] = 32'hB;
      issue_valid = 1'b0; issue_rd = '0;
      regA = '0; regB = '0;

      // 1: reset held with requests active
      repeat (3) begin
         @(negedge clk);
         chk("rst_wr_en", wr_en, 0);
         chk("rst_ready", req_ready, 0);
         chk("rst_busy_a", busy_a, 0);
         chk("rst_busy_b", busy_b, 0);
      end
      step(); rst = 1'b1;

      // 2: both requesters, grants alternate 0,1,0,1
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rr_ready", req_ready, (k % 2) ? 2'b10 : 2'b01);
         if (k > 0) begin
            chk("rr_wr_en", wr_en, 1);
            chk("rr_regW", regW, (k % 2) ? 5 : 6);
            chk("rr_portW", portW, (k % 2) ? 32'hA : 32'hB);
         end
         step();
      end
      req_valid = 2'b00;
      @(negedge clk);
      chk("rr_last_wr_en", wr_en, 1);
      chk("rr_last_regW", regW, 6);
      chk("rr_last_portW", portW, 32'hB);
      step();
      @(negedge clk);
      chk("rr_idle_wr_en", wr_en, 0);

      // 3: write to x0 is granted but never written
      step();
      req_valid = 2'b10; req_rd[1] = 5'd0; req_data[1] = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("x0_ready", req_ready, 2'b10);
      step(); req_valid = 2'b00;
      @(negedge clk);
      chk("x0_wr_en", wr_en, 0);
      step();
      @(negedge clk);
      chk("x0_rf", rf_mem[0], 0);

      // 4: scoreboard set, clear, and set-wins-over-clear
      step(); issue_valid = 1'b1; issue_rd = 5'd7;
      step(); issue_valid = 1'b0; regA = 5'd7;
      req_valid = 2'b01; req_rd[0] = 5'd7; req_data[0] = 32'h77;
      @(negedge clk);
      chk("sb_set_busy_a", busy_a, 1);
      step(); req_valid = 2'b00;
      @(negedge clk);
      chk("sb_wr_en", wr_en, 1);
      chk("sb_regW", regW, 7);
      chk("sb_busy_during_wr", busy_a, 1);
      step();
      @(negedge clk);
      chk("sb_clear_busy_a", busy_a, 0);
      step(); issue_valid = 1'b1; issue_rd = 5'd7;
      step(); issue_valid = 1'b0;
      req_valid = 2'b01; req_rd[0] = 5'd7; req_data[0] = 32'h99;
      step(); req_valid = 2'b00; issue_valid = 1'b1; issue_rd = 5'd7;
      @(negedge clk);
      chk("sb_same_edge_wr_en", wr_en, 1);
      step(); issue_valid = 1'b0;
      @(negedge clk);
      chk("sb_set_wins", busy_a, 1);

      // 5: reset with a write in flight
      step(); regB = 5'd7;
      req_valid = 2'b11; req_rd[0] = 5'd9; req_rd[1] = 5'd10;
      req_data[0] = 32'h90; req_data[1] = 32'hA0;
      step(); rst = 1'b0;
      #1;
      chk("mid_rst_wr_en", wr_en, 0);
      chk("mid_rst_busy_a", busy_a, 0);
      chk("mid_rst_busy_b", busy_b, 0);
      chk("mid_rst_commits", commits, 6);
      repeat (2) @(negedge clk);
      chk("mid_rst_no_commit", commits, 6);
      chk("mid_rst_rf10", rf_mem[10], 0);
      chk("mid_rst_rf9", rf_mem[9], 0);
      step(); req_valid = 2'b00; rst = 1'b1;
      @(negedge clk);
      chk("post_rst_wr_en", wr_en, 0);
      chk("post_rst_ready", req_ready, 0);

`ifdef WB_FWD_EN
      // 6: forwarding covers the write the synchronous read misses
      step(); regA = 5'd3;
      req_valid = 2'b01; req_rd[0] = 5'd3; req_data[0] = 32'h1234;
      step(); req_valid = 2'b00;
      step();
      @(negedge clk);
      chk("fwd_portA", portA, 32'h1234);
      chk("fwd_rf_portA_old", rf_portA, 0);
      step();
      @(negedge clk);
      chk("fwd_rf_portA_new", rf_portA, 32'h1234);
      chk("fwd_portA_after", portA, 32'h1234);
`endif

      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
